// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes upstream instruction field sets (op, rs, rt, rd, imm)
//               into 32-bit instruction words and queues them in a DEPTH-entry
//               FIFO for a downstream control unit. Both sides use
//               valid/ready handshakes.
// Parameters  : DEPTH - queue depth in words (2, 4 or 8)
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous active-high reset
//               in_valid  - field set present
//               in_ready  - queue can accept a field set (count < DEPTH)
//               in_op     - 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 LW, 6 LW1,
//                           7 illegal
//               in_rs/in_rt/in_rd - register indices
//               in_imm    - LW/LW1 offset
//               out_valid - out_instr holds a valid word (count != 0)
//               out_ready - downstream consumes the head word
//               out_instr - head word, zero when empty
//               count     - number of queued words
//               err       - sticky illegal-op flag
// Config      : INSTR_ENC_CHECK_EN - when defined, op 7 is accepted but
//               dropped and sets err; otherwise op 7 queues a zero word and
//               err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [4:0]                 in_rs,
    input  logic [4:0]                 in_rt,
    input  logic [4:0]                 in_rd,
    input  logic [15:0]                in_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [5:0] c_opc_rtype = 6'b001111;
    localparam logic [5:0] c_opc_lw    = 6'b010000;
    localparam logic [5:0] c_opc_lw1   = 6'b010001;
    localparam logic [4:0] c_shamt     = 5'd10;

    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_mul = 6'b110010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;

    localparam logic [2:0] c_op_illegal = 3'd7;

    logic [31:0]        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;

    logic [31:0]        w_enc;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_enq;
    logic               w_illegal;

    // ------------------------------------------------------------------
    // Field-set encoder
    // ------------------------------------------------------------------
    always_comb begin
        w_enc = 32'h0000_0000;
        case (in_op)
            3'd0: w_enc = {c_opc_rtype, in_rs, in_rt, in_rd, c_shamt, c_fn_add};
            3'd1: w_enc = {c_opc_rtype, in_rs, in_rt, in_rd, c_shamt, c_fn_sub};
            3'd2: w_enc = {c_opc_rtype, in_rs, in_rt, in_rd, c_shamt, c_fn_mul};
            3'd3: w_enc = {c_opc_rtype, in_rs, in_rt, in_rd, c_shamt, c_fn_and};
            3'd4: w_enc = {c_opc_rtype, in_rs, in_rt, in_rd, c_shamt, c_fn_or};
            3'd5: w_enc = {c_opc_lw,  in_rs, in_rt, in_imm};
            3'd6: w_enc = {c_opc_lw1, in_rs, in_rt, in_imm};
            default: w_enc = 32'h0000_0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes. A full queue never accepts, even when popping in the
    // same cycle, so in_ready depends only on registered state.
    // ------------------------------------------------------------------
    assign w_in_ready  = (r_count < c_cnt_w'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

`ifdef INSTR_ENC_CHECK_EN
    assign w_illegal = (in_op == c_op_illegal);
`else
    assign w_illegal = 1'b0;
`endif

    // An illegal op still completes its handshake but is not stored.
    assign w_enq = w_push && !w_illegal;

    // ------------------------------------------------------------------
    // Queue storage (data needs no reset; visibility is gated by count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_enq) begin
            r_mem[r_wptr] <= w_enc;
        end
    end

    // Pointers are log2(DEPTH) wide so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_push && w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_instr = w_out_valid ? r_mem[r_rptr] : 32'h0000_0000;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder. A queue-based
//               reference model predicts queue contents, count and err from
//               the encoding tables and handshake rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [15:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq [$];
    logic        merr;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef INSTR_ENC_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // Reference encoding straight from the opcode/funct tables.
    function automatic logic [31:0] ref_encode(input logic [2:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [15:0] imm);
        logic [5:0] funct;
        funct = 6'd0;
        if (op <= 3'd4) begin
            case (op)
                3'd0: funct = 6'b100000;
                3'd1: funct = 6'b100010;
                3'd2: funct = 6'b110010;
                3'd3: funct = 6'b100100;
                default: funct = 6'b100101;
            endcase
            return (32'(6'b001111) << 26) | (32'(rs) << 21) | (32'(rt) << 16) |
                   (32'(rd) << 11) | (32'd10 << 6) | 32'(funct);
        end else if (op == 3'd5) begin
            return (32'(6'b010000) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        end else if (op == 3'd6) begin
            return (32'(6'b010001) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        end
        return 32'h0;
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit          do_push;
        bit          do_pop;
        logic [31:0] w;
        logic [31:0] dummy;
        do_pop  = (mq.size() != 0) && out_ready;
        do_push = in_valid && (mq.size() < DEPTH);
        w       = ref_encode(in_op, in_rs, in_rt, in_rd, in_imm);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            merr = 1'b0;
        end else begin
            if (do_pop) dummy = mq.pop_front();
            if (do_push) begin
                if (CHECK_EN && in_op == 3'd7) merr = 1'b1;
                else mq.push_back(w);
            end
        end
        #1;
    endtask

    function automatic logic [31:0] exp_head();
        return (mq.size() != 0) ? mq[0] : 32'h0;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    endtask

    task automatic drive_random();
        drive(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        drive(3'd0, 5'd1, 5'd2, 5'd3, 16'd0);
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 00000000", out_instr); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_lw();
        drive(3'd5, 5'd0, 5'd1, 5'd0, 16'd0);
        in_valid = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lw_latency got out_valid=%b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL lw_valid got %b want 1", out_valid); end
        checks++;
        if (out_instr !== 32'h40010000) begin errors++; $display("FAIL lw_word got %h want 40010000", out_instr); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_instr !== 32'h0 || count !== '0) begin
            errors++; $display("FAIL lw_drain got instr=%h count=%0d want 00000000/0", out_instr, count);
        end
    endtask

    task automatic test_rtype_burst();
        logic [31:0] want [3];
        want[0] = 32'h3C221AA0; want[1] = 32'h3C221AA2; want[2] = 32'h3C221AB2;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(3'(i), 5'd1, 5'd2, 5'd3, 16'hFFFF);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== CW'(3)) begin errors++; $display("FAIL rtype_count got %0d want 3", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_instr !== want[i]) begin errors++; $display("FAIL rtype_word%0d got %h want %h", i, out_instr, want[i]); end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rtype_empty got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_full();
        logic [31:0] first;
        out_ready = 1'b0; in_valid = 1'b1;
        first = 32'h0;
        for (int i = 0; i < 5; i++) begin
            drive(3'd6, 5'(i), 5'(i + 1), 5'd0, 16'(16'h1000 + i));
            if (i == 0) first = ref_encode(3'd6, 5'd0, 5'd1, 5'd0, 16'h1000);
            tick();
            if (i == 3) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
            end
        end
        checks++;
        if (count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count got %0d want %0d", count, DEPTH); end
        checks++;
        if (out_instr !== first) begin errors++; $display("FAIL full_head got %h want %h", out_instr, first); end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_instr !== first || count !== CW'(DEPTH)) begin
            errors++; $display("FAIL full_hold got instr=%h count=%0d want %h/%0d", out_instr, count, first, DEPTH);
        end
    endtask

    // Starts from a full queue: stream with both sides always willing.
    task automatic test_full_stream();
        int guard;
        in_valid = 1'b1; out_ready = 1'b1;
        drive_random();
        if (in_op == 3'd7) in_op = 3'd0;
        for (int i = 0; i < 12; i++) begin
            bit accepted;
            accepted = (mq.size() < DEPTH);
            tick();
            checks++;
            if (out_instr !== exp_head() || count !== CW'(mq.size()) || in_ready !== (mq.size() < DEPTH)) begin
                errors++;
                $display("FAIL stream_cyc%0d got instr=%h count=%0d rdy=%b want %h/%0d/%b",
                         i, out_instr, count, in_ready, exp_head(), mq.size(), mq.size() < DEPTH);
            end
            if (accepted) begin
                drive_random();
                if (in_op == 3'd7) in_op = 3'd1;
            end
        end
        in_valid = 1'b0;
        guard = 0;
        while (mq.size() != 0 && guard < 20) begin
            checks++;
            if (out_instr !== exp_head()) begin errors++; $display("FAIL stream_drain got %h want %h", out_instr, exp_head()); end
            tick();
            guard++;
        end
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_end got count=%0d valid=%b want 0/0", count, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        out_ready = 1'b0; in_valid = 1'b1;
        drive(3'd6, 5'd0, 5'd3, 5'd9, 16'd3);
        tick();
        drive(3'd7, 5'd4, 5'd5, 5'd6, 16'h1234);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_instr !== 32'h44030003) begin errors++; $display("FAIL illegal_head got %h want 44030003", out_instr); end
        checks++;
        if (count !== (CHECK_EN ? CW'(1) : CW'(2))) begin
            errors++; $display("FAIL illegal_count got %0d want %0d", count, CHECK_EN ? 1 : 2);
        end
        checks++;
        if (err !== CHECK_EN) begin errors++; $display("FAIL illegal_err got %b want %b", err, CHECK_EN); end
        // Mid-stream reset with a push and pop requested in the same cycle.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        drive(3'd0, 5'd1, 5'd1, 5'd1, 16'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (err !== 1'b0 || count !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL illegal_rst got err=%b count=%0d valid=%b want 0/0/0", err, count, out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            drive_random();
            tick();
            checks++;
            if (count !== CW'(mq.size())) begin errors++; $display("FAIL rand_count cyc%0d got %0d want %0d", i, count, mq.size()); end
            checks++;
            if (out_instr !== exp_head()) begin errors++; $display("FAIL rand_instr cyc%0d got %h want %h", i, out_instr, exp_head()); end
            checks++;
            if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rand_valid cyc%0d got %b want %b", i, out_valid, mq.size() != 0); end
            checks++;
            if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rand_ready cyc%0d got %b want %b", i, in_ready, mq.size() < DEPTH); end
            checks++;
            if (err !== merr) begin errors++; $display("FAIL rand_err cyc%0d got %b want %b", i, err, merr); end
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        merr = 1'b0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(3'd0, 5'd0, 5'd0, 5'd0, 16'd0);
        #1;
        test_reset();
        test_lw();
        test_rtype_burst();
        test_full();
        test_full_stream();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning output queue depth in instruction words; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream field set present.
REQ-005 SHALL have port in_ready  output  1  encoder can accept a field set this cycle.
REQ-006 SHALL have port in_op  input  3  operation select: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 LW, 6 LW1, 7 illegal.
REQ-007 SHALL have ports in_rs, in_rt, in_rd  input  5 each  register indices.
REQ-008 SHALL have port in_imm  input  16  offset for LW/LW1.
REQ-009 SHALL have port out_valid  output  1  out_instr holds a valid word.
REQ-010 SHALL have port out_ready  input  1  downstream control unit consumes the word.
REQ-011 SHALL have port out_instr  output  32  encoded instruction at queue head.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  words currently queued.
REQ-013 SHALL have port err  output  1  sticky illegal-op flag.

Function
REQ-014 R-type (op 0-4) SHALL encode [31:26]=6'b001111, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=5'd10, [5:0]=funct.
REQ-015 Funct SHALL be ADD 6'b100000, SUB 6'b100010, MUL 6'b110010, AND 6'b100100, OR 6'b100101.
REQ-016 LW SHALL encode [31:26]=6'b010000, LW1 [31:26]=6'b010001; [25:21]=rs, [20:16]=rt, [15:0]=in_imm; in_rd ignored.
REQ-017 Push SHALL occur when in_valid && in_ready; in_ready SHALL equal (count < DEPTH), no same-cycle bypass when full.
REQ-018 Pop SHALL occur when out_valid && out_ready; out_valid SHALL equal (count != 0).
REQ-019 Latency: a pushed word SHALL appear on out_instr no earlier than the following cycle; queue is FIFO-ordered.
REQ-020 Simultaneous push and pop with 0 < count <= DEPTH-1 SHALL leave count unchanged and preserve order.
REQ-021 Simultaneous push and pop at count == DEPTH SHALL perform pop only (in_ready is 0).
REQ-022 Read/write pointers SHALL wrap modulo DEPTH.
REQ-023 When empty, out_instr SHALL be 32'h00000000.
REQ-024 out_instr and out_valid SHALL be stable while out_valid && !out_ready.

Reset
REQ-025 On rst high at a rising edge: count=0, pointers=0, out_valid=0, out_instr=0, err=0; in_ready=1 from the next cycle.
REQ-026 rst asserted mid-stream SHALL discard all queued words; any push or pop in that cycle SHALL be ignored.

Configuration
REQ-027 Macro INSTR_ENC_CHECK_EN defined: op 7 push SHALL be consumed (handshake completes), not enqueued, and set err=1 until rst.
REQ-028 Macro INSTR_ENC_CHECK_EN undefined: err SHALL be tied 0 and op 7 SHALL enqueue 32'h00000000.

Verification
REQ-029 Push LW rs=0 rt=1 imm=0 -> next cycle out_valid=1, out_instr=32'h40010000.
REQ-030 Push ADD, SUB, MUL (rs=1 rt=2 rd=3) with out_ready=0 -> count=3; then out_ready=1 -> 32'h3C221AA0, 32'h3C221AA2, 32'h3C221AB2 on consecutive cycles.
REQ-031 Push 5 words with out_ready=0, DEPTH=4 -> in_ready=0 after 4th, 5th held off; count=4.
REQ-032 Full queue, in_valid=1 and out_ready=1 continuously -> one pop per cycle, push resumes the cycle after in_ready rises, no word lost or duplicated.
REQ-033 Push LW1 rt=3 imm=3 then op 7 (INSTR_ENC_CHECK_EN defined) -> 32'h44030003 only, err=1; rst -> err=0, count=0, out_valid=0.
